// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcodes, FSM encoding and counter sizing shared by the
// iterative multiply/divide unit.
package muldiv_pkg;

   localparam logic [3:0] ALU_MUL   = 4'b0111;
   localparam logic [3:0] ALU_UMULL = 4'b0101;
   localparam logic [3:0] ALU_SMULL = 4'b0110;
   localparam logic [3:0] ALU_DIV   = 4'b0100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX,
      ST_DONE
   } state_t;

   function automatic int cnt_w(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int CNT_W = cnt_w(32);

   function automatic logic is_valid_op(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_UMULL) ||
             (op == ALU_SMULL) || (op == ALU_DIV);
   endfunction

endpackage

// File: rtl/muldiv_iter_unit_if.sv
// muldiv_iter_unit_if: request/result bundle between decode, the
// multiply/divide unit and writeback.
interface muldiv_iter_unit_if #(parameter int WIDTH = 32);

   logic             Start;
   logic [3:0]       ALUControl;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Result;
   logic [WIDTH-1:0] ResultHi;
   logic             DivByZero;
   logic             ResultN;
   logic             ResultZ;

   modport master (
      output Start, ALUControl, SrcA, SrcB,
      input  Busy, Done, Result, ResultHi,
      input  DivByZero, ResultN, ResultZ
   );

   modport slave (
      input  Start, ALUControl, SrcA, SrcB,
      output Busy, Done, Result, ResultHi,
      output DivByZero, ResultN, ResultZ
   );

endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate, used both for
// operand magnitudes and for restoring the sign of a long product.
module muldiv_sign_fix #(
   parameter int N = 32
) (
   input  logic [N-1:0] i_val,
   input  logic         i_neg,
   output logic [N-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + N'(1)) : i_val;

endmodule

// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: radix-2 multiply / restoring divide, one bit per cycle.
// Define MULDIV_EARLY_TERM_EN to end multiplies once the multiplier runs out.
module muldiv_iter_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic reset,
   muldiv_iter_unit_if.slave bus
);

   localparam int CW = cnt_w(WIDTH);
   localparam int W2 = 2 * WIDTH;

   state_t           r_state;
   logic [3:0]       r_op;
   logic [CW-1:0]    r_cnt;
   logic             r_neg;
   logic [W2-1:0]    r_prod;
   logic [W2-1:0]    r_mcand;
   logic [WIDTH-1:0] r_mplr;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_div;
   logic             r_busy;
   logic             r_done;
   logic             r_dbz;
   logic             r_n;
   logic             r_z;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_hi;

   logic             w_smull;
   logic             w_long;
   logic             w_last;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [W2-1:0]    w_fixed;
   logic [W2-1:0]    w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;

   assign w_smull = (bus.ALUControl == ALU_SMULL);
   assign w_long  = (r_op == ALU_UMULL) || (r_op == ALU_SMULL);

   muldiv_sign_fix #(.N(WIDTH)) u_abs_a (
      .i_val (bus.SrcA),
      .i_neg (w_smull & bus.SrcA[WIDTH-1]),
      .o_val (w_abs_a)
   );

   muldiv_sign_fix #(.N(WIDTH)) u_abs_b (
      .i_val (bus.SrcB),
      .i_neg (w_smull & bus.SrcB[WIDTH-1]),
      .o_val (w_abs_b)
   );

   muldiv_sign_fix #(.N(W2)) u_fix (
      .i_val (r_prod),
      .i_neg (r_neg),
      .o_val (w_fixed)
   );

   assign w_sum   = r_mplr[0] ? (r_prod + r_mcand) : r_prod;
   // r_mplr doubles as dividend shift-out / quotient shift-in
   assign w_shift = {r_rem, r_mplr[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, r_div};

`ifdef MULDIV_EARLY_TERM_EN
   assign w_last = (r_cnt == CW'(WIDTH - 1)) ||
                   (r_mplr[WIDTH-1:1] == '0);
`else
   assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_op    <= '0;
         r_cnt   <= '0;
         r_neg   <= 1'b0;
         r_prod  <= '0;
         r_mcand <= '0;
         r_mplr  <= '0;
         r_rem   <= '0;
         r_div   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
         r_n     <= 1'b0;
         r_z     <= 1'b1;
         r_res   <= '0;
         r_hi    <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (bus.Start && is_valid_op(bus.ALUControl)) begin
                  r_op   <= bus.ALUControl;
                  r_cnt  <= '0;
                  r_busy <= 1'b1;
                  r_dbz  <= 1'b0;
                  r_prod <= '0;
                  r_rem  <= '0;
                  r_neg  <= w_smull &
                            (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
                  if (bus.ALUControl == ALU_DIV) begin
                     r_mplr  <= bus.SrcA;
                     r_div   <= bus.SrcB;
                     r_mcand <= '0;
                     r_state <= ST_DIV;
                  end else begin
                     r_mplr  <= w_abs_b;
                     r_div   <= '0;
                     r_mcand <= W2'(w_abs_a);
                     r_state <= ST_MUL;
                  end
               end
            end
            ST_MUL: begin
               r_prod  <= w_sum;
               r_mcand <= r_mcand << 1;
               r_mplr  <= r_mplr >> 1;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) r_state <= ST_FIX;
            end
            ST_DIV: begin
               if (r_div == '0) begin
                  r_res   <= '1;
                  r_hi    <= r_mplr;
                  r_dbz   <= 1'b1;
                  r_n     <= 1'b1;
                  r_z     <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_rem  <= w_diff[WIDTH] ? w_shift[WIDTH-1:0]
                                          : w_diff[WIDTH-1:0];
                  r_mplr <= {r_mplr[WIDTH-2:0], ~w_diff[WIDTH]};
                  r_cnt  <= r_cnt + CW'(1);
                  if (r_cnt == CW'(WIDTH - 1)) r_state <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (r_op == ALU_DIV) begin
                  r_res <= r_mplr;
                  r_hi  <= r_rem;
                  r_n   <= r_mplr[WIDTH-1];
                  r_z   <= (r_mplr == '0);
               end else begin
                  r_res <= w_fixed[WIDTH-1:0];
                  r_hi  <= w_fixed[W2-1:WIDTH];
                  r_n   <= w_long ? w_fixed[W2-1] : w_fixed[WIDTH-1];
                  r_z   <= w_long ? (w_fixed == '0)
                                  : (w_fixed[WIDTH-1:0] == '0);
               end
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.Busy      = r_busy;
   assign bus.Done      = r_done;
   assign bus.Result    = r_res;
   assign bus.ResultHi  = r_hi;
   assign bus.DivByZero = r_dbz;
   assign bus.ResultN   = r_n;
   assign bus.ResultZ   = r_z;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// tb_muldiv_iter_unit: random stimulus with a queue scoreboard checked
// against a plain-arithmetic reference model.
module tb_muldiv_iter_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic        dbz;
      logic        n;
      logic        z;
      int          acc;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   int   done_cnt = 0;
   exp_t sbq[$];

   muldiv_iter_unit_if #(.WIDTH(W)) bus();

   muldiv_iter_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, want %h", nm, act, req);
   endtask

   function automatic exp_t model(input logic [3:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t        e;
      logic [63:0] p;
      longint      sa;
      longint      sb;
      logic        lng;
      e.dbz = 1'b0;
      e.lat = 33;
      e.acc = 0;
      p = '0;
      lng = (op == ALU_UMULL) || (op == ALU_SMULL);
      if (op == ALU_DIV) begin
         if (b == 0) begin
            e.res = 32'hFFFF_FFFF;
            e.hi  = a;
            e.dbz = 1'b1;
            e.lat = 1;
         end else begin
            e.res = a / b;
            e.hi  = a % b;
         end
      end else begin
         if (op == ALU_SMULL) begin
            sa = $signed(a);
            sb = $signed(b);
            p = 64'(sa * sb);
         end else begin
            p = {32'b0, a} * {32'b0, b};
         end
         e.res = p[31:0];
         e.hi  = p[63:32];
      end
      e.n = lng ? e.hi[31] : e.res[31];
      e.z = lng ? ({e.hi, e.res} == 64'd0) : (e.res == 32'd0);
`ifdef MULDIV_EARLY_TERM_EN
      if (op != ALU_DIV) begin
         logic [31:0] m;
         int bits;
         m = (op == ALU_SMULL && b[31]) ? -b : b;
         bits = 1;
         for (int i = 0; i < 32; i++) if (m[i]) bits = i + 1;
         e.lat = bits + 1;
      end
`endif
      return e;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.Done === 1'b1) begin
         done_cnt++;
         chk("done_expected", 64'(sbq.size() != 0), 64'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("Result", 64'(bus.Result), 64'(e.res));
            chk("ResultHi", 64'(bus.ResultHi), 64'(e.hi));
            chk("DivByZero", 64'(bus.DivByZero), 64'(e.dbz));
            chk("ResultN", 64'(bus.ResultN), 64'(e.n));
            chk("ResultZ", 64'(bus.ResultZ), 64'(e.z));
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
         end
      end
   end

   task automatic drive(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit push,
                        output int acc);
      exp_t e;
      @(posedge clk); #1;
      bus.Start = 1'b1;
      bus.ALUControl = op;
      bus.SrcA = a;
      bus.SrcB = b;
      acc = cyc + 1;
      if (push) begin
         e = model(op, a, b);
         e.acc = acc;
         sbq.push_back(e);
      end
      @(posedge clk); #1;
      bus.Start = 1'b0;
      bus.SrcA = $urandom;
      bus.SrcB = $urandom;
      bus.ALUControl = 4'($urandom);
   endtask

   task automatic wait_done(input int d0);
      int i;
      i = 0;
      while (done_cnt == d0 && i < 45) begin
         @(posedge clk);
         i++;
      end
      chk("done_timeout", 64'(done_cnt != d0), 64'd1);
   endtask

   task automatic run(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
      int d0;
      int acc;
      d0 = done_cnt;
      drive(op, a, b, 1'b1, acc);
      wait_done(d0);
   endtask

   task automatic pulse_at(input int e);
      while (cyc < e - 1) begin
         @(posedge clk); #1;
      end
      bus.Start = 1'b1;
      bus.ALUControl = ALU_DIV;
      bus.SrcA = 32'd9;
      bus.SrcB = 32'd3;
      @(posedge clk); #1;
      bus.Start = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int acc;
      int d0;
      int sel;
      logic [3:0] bad[4];
      logic [3:0] ops[4];
      logic [31:0] a;
      logic [31:0] b;
      bad = '{4'b0000, 4'b1111, 4'b0001, 4'b1000};
      ops = '{ALU_MUL, ALU_UMULL, ALU_SMULL, ALU_DIV};
      bus.Start = 1'b0;
      bus.ALUControl = '0;
      bus.SrcA = '0;
      bus.SrcB = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst_Busy", 64'(bus.Busy), 64'd0);
      chk("rst_Done", 64'(bus.Done), 64'd0);
      chk("rst_Result", 64'(bus.Result), 64'd0);
      chk("rst_ResultHi", 64'(bus.ResultHi), 64'd0);
      chk("rst_DivByZero", 64'(bus.DivByZero), 64'd0);
      chk("rst_ResultN", 64'(bus.ResultN), 64'd0);
      chk("rst_ResultZ", 64'(bus.ResultZ), 64'd1);

      run(ALU_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(ALU_SMULL, 32'hFFFF_FFFE, 32'd3);
      run(ALU_MUL, 32'h0001_0000, 32'h0001_0000);
      run(ALU_MUL, 32'd7, 32'd1);
      run(ALU_DIV, 32'd100, 32'd7);
      run(ALU_DIV, 32'd5, 32'd0);

      d0 = done_cnt;
      drive(ALU_MUL, 32'd3, 32'd5, 1'b1, acc);
      chk("dbz_clear_on_accept", 64'(bus.DivByZero), 64'd0);
      chk("result_held", 64'(bus.Result), 64'hFFFF_FFFF);
      chk("busy_running", 64'(bus.Busy), 64'd1);
      wait_done(d0);

      foreach (bad[k]) begin
         d0 = done_cnt;
         drive(bad[k], 32'd6, 32'd7, 1'b0, acc);
         chk("bad_op_busy", 64'(bus.Busy), 64'd0);
         repeat (3) @(posedge clk);
         #1 chk("bad_op_no_done", 64'(done_cnt - d0), 64'd0);
      end

      d0 = done_cnt;
      drive(ALU_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, acc);
      pulse_at(acc + 5);
      pulse_at(acc + 34);
      repeat (40) @(posedge clk);
      #1;
      chk("single_done", 64'(done_cnt - d0), 64'd1);
      chk("sb_empty_after_ignore", 64'(sbq.size()), 64'd0);

      d0 = done_cnt;
      drive(ALU_MUL, 32'h1234, 32'h5678, 1'b0, acc);
      while (cyc < acc + 9) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_Busy", 64'(bus.Busy), 64'd0);
      chk("abort_Done", 64'(bus.Done), 64'd0);
      chk("abort_Result", 64'(bus.Result), 64'd0);
      chk("abort_ResultHi", 64'(bus.ResultHi), 64'd0);
      chk("abort_ResultZ", 64'(bus.ResultZ), 64'd1);
      chk("abort_ResultN", 64'(bus.ResultN), 64'd0);
      repeat (40) @(posedge clk);
      #1 chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      run(ALU_MUL, 32'h1234, 32'h5678);

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0: b = 32'd0;
            1: b = 32'd1;
            2: b = 32'($urandom_range(0, 255));
            3: b = -32'($urandom_range(1, 255));
            default: b = $urandom;
         endcase
         run(ops[$urandom_range(0, 3)], a, b);
      end

      repeat (5) @(posedge clk);
      #1 chk("sb_drained", 64'(sbq.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
Iterative multi-cycle multiply/divide execution unit, directly downstream of instruction decode. Consumes the 4-bit ALUControl code, SrcA and SrcB, and executes MUL, UMULL, SMULL and DIV over multiple cycles. Returns the low result (Result) and the high result or remainder (ResultHi) to the writeback path. The main FSM stalls on Busy and advances on Done.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH.

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
Start  input  1  request; sampled only in IDLE
ALUControl  input  4  operation code: 0111 MUL, 0101 UMULL, 0110 SMULL, 0100 DIV
SrcA  input  WIDTH  multiplicand or dividend
SrcB  input  WIDTH  multiplier or divisor
Busy  output  1  operation in progress
Done  output  1  one-cycle completion pulse
Result  output  WIDTH  product low word or quotient
ResultHi  output  WIDTH  product high word or remainder
DivByZero  output  1  last DIV had divisor 0
ResultN  output  1  sign bit of the result (Result[WIDTH-1], or ResultHi[WIDTH-1] for long multiplies)
ResultZ  output  1  zero flag: Result is 0, or {ResultHi,Result} is 0 for long multiplies

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE; Busy=0, Done=0, Result=0, ResultHi=0, DivByZero=0, ResultN=0, ResultZ=1.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - Start=1 with a valid code latches the operands and op, clears the iteration counter and sets Busy=1 on the next edge.
  - Operands are latched at the Start edge; later changes on SrcA/SrcB have no effect.
  - Start with any other code is ignored: no state change, no Done.
- MUL (0111, 0101, 0110):
  - Radix-2 shift-add, one multiplier bit per cycle, WIDTH cycles.
  - SMULL uses the magnitudes of both operands; the sign is recorded as SrcA[msb] XOR SrcB[msb].
  - Transitions to FIX.
- DIV (0100):
  - Unsigned restoring division, one quotient bit per cycle, WIDTH cycles.
  - Transitions to FIX.
  - SrcB==0 skips DIV and goes straight to DONE with Result=all-ones, ResultHi=SrcA, DivByZero=1.
- FIX (1 cycle):
  - SMULL with negative sign: 2*WIDTH two's-complement negate of the product.
  - Registers Result, ResultHi, ResultN and ResultZ; goes to DONE.
- DONE (1 cycle): Done=1, Busy=0, then returns to IDLE.
- Latency, Start accepted at edge 0:
  - MUL/DIV: Busy high for WIDTH+1 cycles; Done high in cycle WIDTH+2 (cycle 34 for WIDTH=32).
  - Divide by zero: Done in cycle 2.
- Start asserted while Busy or Done is high is ignored, not queued.
- Done and Start in the same cycle: Start is ignored; the FSM must re-assert Start after returning to IDLE.
- Outputs hold their value from Done until the next accepted operation completes. They are not cleared at Start.
- DivByZero is cleared by any subsequent accepted operation.
- Reset mid-operation aborts immediately: IDLE, all outputs at reset values, no Done pulse.
- MUL (0111): Result is the low word; ResultHi holds the high word but writeback ignores it.
- Arithmetic is modulo 2^(2*WIDTH). No overflow indication.

Optional Feature:
MULDIV_EARLY_TERM_EN
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, the unit jumps straight to FIX. Latency is then data-dependent, minimum 3 cycles to Done (e.g. SrcB=0 or 1). DIV is unaffected.
- Undefined: fixed latency as above.
- Results are bit-identical with and without the macro.

Decomposition:
- Package muldiv_pkg holds:
  - ALUControl localparams: ALU_MUL=4'b0111, ALU_UMULL=4'b0101, ALU_SMULL=4'b0110, ALU_DIV=4'b0100.
  - State encoding (IDLE/MUL/DIV/FIX/DONE).
  - Counter width, $clog2(WIDTH)+1.
- One sub-module, muldiv_sign_fix: combinational magnitude extraction and 2*WIDTH conditional negate. Instantiated for the operand absolute values and for the FIX step.

Test Plan:
- UMULL, SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> Done at cycle 34, ResultHi=0xFFFFFFFE, Result=0x00000001, ResultN=1, ResultZ=0.
- SMULL, SrcA=0xFFFFFFFE (-2), SrcB=3 -> ResultHi=0xFFFFFFFF, Result=0xFFFFFFFA; MUL 0x10000*0x10000 -> Result=0, ResultZ=1.
- DIV 100/7 -> Result=14, ResultHi=2, DivByZero=0; DIV 5/0 -> Done at cycle 2, Result=0xFFFFFFFF, ResultHi=5, DivByZero=1.
- Start (DIV 9/3) pulsed again at cycles 5 and 34 during a running UMULL -> ignored; only one Done, UMULL result correct, no DIV result.
- Reset asserted at cycle 10 of a MUL -> next cycle Busy=0, Result=0, ResultZ=1, and no Done ever appears; a new MUL then completes normally.
- With MULDIV_EARLY_TERM_EN: MUL 7*1 -> Done within 3 cycles, Result=7; same MUL without the macro -> Done at cycle 34, same value.
